ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes op_ex/sel_ex/num1_ex/num2_ex/desReg_addr_ex/en_wd_ex from the de_ex register and feeds the ex_mem register.
- Single-cycle ALU: logic, shift, arithmetic and move result classes, plus a single-cycle MULT/MULTU HI/LO result.
- DIV/DIVU use an embedded iterative radix-2 divider that raises a stall request to ctrl until the quotient and remainder are ready.

Parameters:
- DW, 32, datapath width; must equal `DataWidth. The divider iteration count equals DW.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_ex  in  8  operation code (`EXE_*_OP)
- sel_ex  in  3  result class (`EXE_RES_*)
- num1_ex  in  DW  operand A (rs or shamt path)
- num2_ex  in  DW  operand B (rt or immediate)
- desReg_addr_ex  in  `Reg_AddrBus  destination register
- en_wd_ex  in  1  register write enable
- stop  in  `StopWidth  ctrl stall vector; stop[3] = EX hold
- wdata  out  DW  GPR write data
- desReg_addr  out  `Reg_AddrBus  passthrough of desReg_addr_ex
- en_wd  out  1  write enable; forced 0 on add/sub overflow
- whilo  out  1  HI/LO write enable
- hi  out  DW  HI write data
- lo  out  DW  LO write data
- stopreq_ex  out  1  stall request to ctrl

Behaviour:
- Reset (async, rst_n=0):
  - Divider FSM returns to IDLE; internal dividend/divisor/quotient/remainder registers and the 6-bit iteration counter clear to 0.
  - stopreq_ex=0, whilo=0, wdata=0, hi=0, lo=0, en_wd=0, desReg_addr=0.
- ALU (combinational, zero latency), by sel_ex:
  - LOGIC: AND, OR, XOR, NOR.
  - SHIFT: SLL, SRL, SRA, using num1_ex[4:0] as the shift amount applied to num2_ex.
  - ARITH: ADD, ADDU, SUB, SUBU, SLT (signed), SLTU (unsigned).
  - NOP or unknown sel_ex: wdata=0.
- Overflow: signed overflow on ADD/SUB forces en_wd=0; ADDU/SUBU never trap.
- MULT/MULTU: full 2*DW-bit product, hi=upper half, lo=lower half, whilo=1 in the same cycle. Signed multiply negates operands, then the product, as required.
- Divider FSM states: IDLE, BUSY, DZERO, DONE.
- IDLE:
  - On op_ex = DIV or DIVU: if num2_ex == 0, go to DZERO; otherwise latch |num1_ex| and |num2_ex| (raw values for DIVU), record the quotient sign (DIV: sign A xor sign B) and remainder sign (sign A), clear counter, go to BUSY.
  - stopreq_ex=1 combinationally in the cycle the DIV is first seen.
- BUSY:
  - One restoring shift/subtract step per cycle; counter increments.
  - When counter reaches DW-1, go to DONE.
  - stopreq_ex=1 throughout.
- DZERO:
  - One cycle, stopreq_ex=1, then go to DONE with quotient=0 and remainder=0.
- DONE:
  - stopreq_ex=0.
  - lo = signed-corrected quotient, hi = signed-corrected remainder, whilo=1.
  - Exit to IDLE when stop[3]==`NoStop; otherwise stay in DONE holding the result (downstream stall).
- Latency: non-zero DIV takes DW+2 cycles of EX occupancy (1 IDLE + DW BUSY + 1 DONE); DIV by zero takes 3.
- Restart protection: the ex_mem/de_ex advance happens on the DONE-exit edge, so IDLE never re-triggers on the same instruction.
- Non-DIV ops while the FSM is in IDLE: stopreq_ex=0.
- Reset mid-division: immediate abort to IDLE; no HI/LO write is issued.
- Signed edge case: 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0; no trap.

Decomposition:
- define.v (shared) holds: op codes including EXE_DIV_OP, EXE_DIVU_OP, EXE_MULT_OP, EXE_MULTU_OP; sel codes; `Stop/`NoStop; `StopWidth; FSM state encodings DIV_IDLE, DIV_BUSY, DIV_DZERO, DIV_DONE.
- Sub-module div_unit holds the FSM and datapath, with a start / signed / opA / opB / result / ready interface.
- ex_stage holds the ALU, multiplier, muxing and stopreq generation.

Test Plan:
- ADD 0x7FFFFFFF + 1 -> wdata=0x80000000, en_wd=0. ADDU with the same operands -> en_wd=1.
- SRA with num1_ex=4, num2_ex=0xF0000000 -> wdata=0xFF000000. SLTU 1 vs 0xFFFFFFFF -> wdata=1.
- MULT 0xFFFFFFFE * 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, whilo=1; stopreq_ex stays 0.
- DIV -7 / 2 -> stopreq_ex high for exactly 33 cycles; DONE cycle lo=0xFFFFFFFD, hi=0xFFFFFFFF, whilo=1. Then DIVU 100/7 -> lo=14, hi=2.
- DIVU x/0 -> stopreq_ex high 2 cycles, then hi=0, lo=0. Hold stop[3]=`Stop during DONE for 3 cycles -> result held; no restart.
- Drop rst_n during BUSY at iteration 10 -> stopreq_ex=0 immediately; FSM in IDLE; no whilo pulse after release.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: op codes, result classes, stall vector
// layout and the divider FSM states.
package ex_stage_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned RegAddrW  = 5;
  localparam int unsigned StopWidth = 6;
  localparam int unsigned StopExBit = 3;
  localparam int unsigned CntW      = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [7:0] ExeNopOp   = 8'b0000_0000;
  localparam logic [7:0] ExeAndOp   = 8'b0010_0100;
  localparam logic [7:0] ExeOrOp    = 8'b0010_0101;
  localparam logic [7:0] ExeXorOp   = 8'b0010_0110;
  localparam logic [7:0] ExeNorOp   = 8'b0010_0111;
  localparam logic [7:0] ExeSllOp   = 8'b0111_1100;
  localparam logic [7:0] ExeSrlOp   = 8'b0000_0010;
  localparam logic [7:0] ExeSraOp   = 8'b0000_0011;
  localparam logic [7:0] ExeMovzOp  = 8'b0000_1010;
  localparam logic [7:0] ExeMovnOp  = 8'b0000_1011;
  localparam logic [7:0] ExeAddOp   = 8'b0010_0000;
  localparam logic [7:0] ExeAdduOp  = 8'b0010_0001;
  localparam logic [7:0] ExeSubOp   = 8'b0010_0010;
  localparam logic [7:0] ExeSubuOp  = 8'b0010_0011;
  localparam logic [7:0] ExeSltOp   = 8'b0010_1010;
  localparam logic [7:0] ExeSltuOp  = 8'b0010_1011;
  localparam logic [7:0] ExeMultOp  = 8'b0001_1000;
  localparam logic [7:0] ExeMultuOp = 8'b0001_1001;
  localparam logic [7:0] ExeDivOp   = 8'b0001_1010;
  localparam logic [7:0] ExeDivuOp  = 8'b0001_1011;

  localparam logic [2:0] ExeResNop   = 3'b000;
  localparam logic [2:0] ExeResLogic = 3'b001;
  localparam logic [2:0] ExeResShift = 3'b010;
  localparam logic [2:0] ExeResMove  = 3'b011;
  localparam logic [2:0] ExeResArith = 3'b100;
  localparam logic [2:0] ExeResMul   = 3'b101;

  typedef enum logic [1:0] {
    DivIdle  = 2'b00,
    DivBusy  = 2'b01,
    DivDzero = 2'b10,
    DivDone  = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// sign correction applied on the registered quotient/remainder while in DONE.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned DW = DataWidth
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [DW-1:0]   i_op_a,
  input  logic [DW-1:0]   i_op_b,
  input  logic            i_hold,
  output logic [2*DW-1:0] o_result,
  output logic            o_ready,
  output logic            o_busy
);

  div_state_e      r_state, w_state_next;
  logic [DW-1:0]   r_dividend, r_divisor, r_quot, r_rem;
  logic [CntW-1:0] r_cnt;
  logic            r_q_neg, r_r_neg;

  logic [DW-1:0]   w_abs_a, w_abs_b;
  logic [DW:0]     w_rem_sh, w_diff;
  logic            w_ge;
  logic [DW-1:0]   w_rem_next;

  assign w_abs_a = (i_signed && i_op_a[DW-1]) ? -i_op_a : i_op_a;
  assign w_abs_b = (i_signed && i_op_b[DW-1]) ? -i_op_b : i_op_b;

  // Remainder is kept below the divisor, so the shifted value needs one extra bit.
  assign w_rem_sh   = {r_rem, r_dividend[DW-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_divisor};
  assign w_ge       = ~w_diff[DW];
  assign w_rem_next = w_ge ? w_diff[DW-1:0] : w_rem_sh[DW-1:0];

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_ready      = 1'b0;
    unique case (r_state)
      DivIdle: begin
        if (i_start) begin
          o_busy       = 1'b1;
          w_state_next = (i_op_b == '0) ? DivDzero : DivBusy;
        end
      end
      DivBusy: begin
        o_busy = 1'b1;
        if (r_cnt == CntW'(DW - 1)) w_state_next = DivDone;
      end
      DivDzero: begin
        o_busy       = 1'b1;
        w_state_next = DivDone;
      end
      DivDone: begin
        o_ready = 1'b1;
        if (!i_hold) w_state_next = DivIdle;
      end
      default: w_state_next = DivIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DivIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
    end else begin
      case (r_state)
        DivIdle: begin
          if (i_start) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            if (i_op_b != '0) begin
              r_dividend <= w_abs_a;
              r_divisor  <= w_abs_b;
              r_q_neg    <= i_signed & (i_op_a[DW-1] ^ i_op_b[DW-1]);
              r_r_neg    <= i_signed & i_op_a[DW-1];
            end
          end
        end
        DivBusy: begin
          r_dividend <= {r_dividend[DW-2:0], 1'b0};
          r_rem      <= w_rem_next;
          r_quot     <= {r_quot[DW-2:0], w_ge};
          r_cnt      <= r_cnt + CntW'(1);
        end
        DivDzero: begin
          r_quot  <= '0;
          r_rem   <= '0;
          r_q_neg <= 1'b0;
          r_r_neg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_result = {(r_r_neg ? -r_rem : r_rem), (r_q_neg ? -r_quot : r_quot)};

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU and multiplier, plus an iterative divider
// that stalls the pipeline through stopreq_ex until its result is ready.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DW = DataWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           op_ex,
  input  logic [2:0]           sel_ex,
  input  logic [DW-1:0]        num1_ex,
  input  logic [DW-1:0]        num2_ex,
  input  logic [RegAddrW-1:0]  desReg_addr_ex,
  input  logic                 en_wd_ex,
  input  logic [StopWidth-1:0] stop,
  output logic [DW-1:0]        wdata,
  output logic [RegAddrW-1:0]  desReg_addr,
  output logic                 en_wd,
  output logic                 whilo,
  output logic [DW-1:0]        hi,
  output logic [DW-1:0]        lo,
  output logic                 stopreq_ex
);

  localparam int unsigned ShW = $clog2(DW);
  localparam int unsigned PW  = 2 * DW;

  logic [DW-1:0]  w_alu, w_sum, w_diff, w_ma, w_mb;
  logic           w_ov, w_mov_we, w_mul_op, w_mul_neg, w_div_op;
  logic [ShW-1:0] w_sh;
  logic [PW-1:0]  w_prod_u, w_prod, w_div_result;
  logic           w_div_ready, w_div_busy;
  logic           w_stop_unused;

  assign w_stop_unused = ^{stop[StopWidth-1:StopExBit+1], stop[StopExBit-1:0]};

  assign w_sh   = num1_ex[ShW-1:0];
  assign w_sum  = num1_ex + num2_ex;
  assign w_diff = num1_ex - num2_ex;

  always_comb begin
    w_alu    = '0;
    w_ov     = 1'b0;
    w_mov_we = 1'b1;
    case (sel_ex)
      ExeResLogic: begin
        case (op_ex)
          ExeAndOp: w_alu = num1_ex & num2_ex;
          ExeOrOp:  w_alu = num1_ex | num2_ex;
          ExeXorOp: w_alu = num1_ex ^ num2_ex;
          ExeNorOp: w_alu = ~(num1_ex | num2_ex);
          default:  w_alu = '0;
        endcase
      end
      ExeResShift: begin
        case (op_ex)
          ExeSllOp: w_alu = num2_ex << w_sh;
          ExeSrlOp: w_alu = num2_ex >> w_sh;
          ExeSraOp: w_alu = $signed(num2_ex) >>> w_sh;
          default:  w_alu = '0;
        endcase
      end
      ExeResMove: begin
        case (op_ex)
          ExeMovzOp: begin
            w_alu    = num1_ex;
            w_mov_we = (num2_ex == '0);
          end
          ExeMovnOp: begin
            w_alu    = num1_ex;
            w_mov_we = (num2_ex != '0);
          end
          default: w_alu = '0;
        endcase
      end
      ExeResArith: begin
        case (op_ex)
          ExeAddOp: begin
            w_alu = w_sum;
            w_ov  = (num1_ex[DW-1] == num2_ex[DW-1]) && (w_sum[DW-1] != num1_ex[DW-1]);
          end
          ExeAdduOp: w_alu = w_sum;
          ExeSubOp: begin
            w_alu = w_diff;
            w_ov  = (num1_ex[DW-1] != num2_ex[DW-1]) && (w_diff[DW-1] != num1_ex[DW-1]);
          end
          ExeSubuOp: w_alu = w_diff;
          ExeSltOp:  w_alu = {{(DW-1){1'b0}}, ($signed(num1_ex) < $signed(num2_ex))};
          ExeSltuOp: w_alu = {{(DW-1){1'b0}}, (num1_ex < num2_ex)};
          default:   w_alu = '0;
        endcase
      end
      default: w_alu = '0;
    endcase
  end

  // Signed multiply runs on magnitudes and re-applies the sign to the full product.
  assign w_mul_op  = (op_ex == ExeMultOp) || (op_ex == ExeMultuOp);
  assign w_ma      = ((op_ex == ExeMultOp) && num1_ex[DW-1]) ? -num1_ex : num1_ex;
  assign w_mb      = ((op_ex == ExeMultOp) && num2_ex[DW-1]) ? -num2_ex : num2_ex;
  assign w_mul_neg = (op_ex == ExeMultOp) && (num1_ex[DW-1] ^ num2_ex[DW-1]);
  assign w_prod_u  = PW'(w_ma) * PW'(w_mb);
  assign w_prod    = w_mul_neg ? -w_prod_u : w_prod_u;

  assign w_div_op = (op_ex == ExeDivOp) || (op_ex == ExeDivuOp);

  div_unit #(
    .DW(DW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_div_op),
    .i_signed (op_ex == ExeDivOp),
    .i_op_a   (num1_ex),
    .i_op_b   (num2_ex),
    .i_hold   (stop[StopExBit] == Stop),
    .o_result (w_div_result),
    .o_ready  (w_div_ready),
    .o_busy   (w_div_busy)
  );

  always_comb begin
    wdata       = w_alu;
    desReg_addr = desReg_addr_ex;
    en_wd       = en_wd_ex & ~w_ov & w_mov_we;
    whilo       = 1'b0;
    hi          = '0;
    lo          = '0;
    stopreq_ex  = w_div_busy;
    if (w_mul_op) begin
      whilo    = 1'b1;
      {hi, lo} = w_prod;
    end else if (w_div_ready) begin
      whilo    = 1'b1;
      {hi, lo} = w_div_result;
    end
    // Outputs read as idle while reset is held, whatever the upstream register shows.
    if (!rst_n) begin
      wdata       = '0;
      desReg_addr = '0;
      en_wd       = 1'b0;
      whilo       = 1'b0;
      hi          = '0;
      lo          = '0;
      stopreq_ex  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for the single-cycle paths, hand-written
// sequences for divider latency, stall hold and mid-division reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk, rst_n;
  logic [7:0]  op_ex;
  logic [2:0]  sel_ex;
  logic [31:0] num1_ex, num2_ex;
  logic [4:0]  desReg_addr_ex;
  logic        en_wd_ex;
  logic [5:0]  stop;
  logic [31:0] wdata, hi, lo;
  logic [4:0]  desReg_addr;
  logic        en_wd, whilo, stopreq_ex;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage #(.DW(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .op_ex          (op_ex),
    .sel_ex         (sel_ex),
    .num1_ex        (num1_ex),
    .num2_ex        (num2_ex),
    .desReg_addr_ex (desReg_addr_ex),
    .en_wd_ex       (en_wd_ex),
    .stop           (stop),
    .wdata          (wdata),
    .desReg_addr    (desReg_addr),
    .en_wd          (en_wd),
    .whilo          (whilo),
    .hi             (hi),
    .lo             (lo),
    .stopreq_ex     (stopreq_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, b;
    logic [31:0] wdata;
    logic        en;
    logic        whilo;
    logic [31:0] hi, lo;
  } vec_t;

  localparam int NVec = 19;
  vec_t vecs [NVec];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts a divide just after a rising edge, counts stall cycles, checks the DONE outputs.
  task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int cnt;
    @(posedge clk);
    #1;
    op_ex   = op;
    sel_ex  = ExeResNop;
    num1_ex = a;
    num2_ex = b;
    @(negedge clk);
    #1;
    cnt = 0;
    while (stopreq_ex && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk({nm, " stall cycles"}, 32'(cnt), 32'(exp_cyc));
    chk({nm, " lo"}, lo, exp_lo);
    chk({nm, " hi"}, hi, exp_hi);
    chk({nm, " whilo"}, 32'(whilo), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{ExeAddOp,   ExeResArith, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{ExeAdduOp,  ExeResArith, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{ExeSraOp,   ExeResShift, 32'h00000004, 32'hF0000000, 32'hFF000000, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{ExeSltuOp,  ExeResArith, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{ExeMultOp,  ExeResNop,   32'hFFFFFFFE, 32'h00000003, 32'h00000000, 1'b1, 1'b1,
                 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[5]  = '{ExeAndOp,   ExeResLogic, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{ExeOrOp,    ExeResLogic, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{ExeXorOp,   ExeResLogic, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{ExeNorOp,   ExeResLogic, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{ExeSllOp,   ExeResShift, 32'h00000008, 32'h000000AB, 32'h0000AB00, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{ExeSrlOp,   ExeResShift, 32'h00000004, 32'hF0000000, 32'h0F000000, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[11] = '{ExeSubOp,   ExeResArith, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[12] = '{ExeSubuOp,  ExeResArith, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[13] = '{ExeSltOp,   ExeResArith, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[14] = '{ExeMultuOp, ExeResNop,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1,
                 32'hFFFFFFFE, 32'h00000001};
    vecs[15] = '{ExeAddOp,   3'b111,      32'h12345678, 32'h11111111, 32'h00000000, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[16] = '{ExeMovzOp,  ExeResMove,  32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[17] = '{ExeMovnOp,  ExeResMove,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[18] = '{ExeAddOp,   ExeResArith, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 1'b1, 1'b0, 32'h0, 32'h0};

    // Reset with live ADD inputs: every output must still read idle.
    rst_n          = 1'b0;
    op_ex          = ExeAddOp;
    sel_ex         = ExeResArith;
    num1_ex        = 32'd1;
    num2_ex        = 32'd2;
    desReg_addr_ex = 5'd7;
    en_wd_ex       = 1'b1;
    stop           = 6'b0;
    #2;
    chk("reset wdata", wdata, 32'h0);
    chk("reset en_wd", 32'(en_wd), 32'h0);
    chk("reset desReg_addr", 32'(desReg_addr), 32'h0);
    chk("reset stopreq_ex", 32'(stopreq_ex), 32'h0);
    chk("reset whilo", 32'(whilo), 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      op_ex          = vecs[i].op;
      sel_ex         = vecs[i].sel;
      num1_ex        = vecs[i].a;
      num2_ex        = vecs[i].b;
      desReg_addr_ex = 5'(i + 1);
      #2;
      chk($sformatf("vec%0d wdata", i), wdata, vecs[i].wdata);
      chk($sformatf("vec%0d en_wd", i), 32'(en_wd), 32'(vecs[i].en));
      chk($sformatf("vec%0d whilo", i), 32'(whilo), 32'(vecs[i].whilo));
      chk($sformatf("vec%0d stopreq_ex", i), 32'(stopreq_ex), 32'h0);
      chk($sformatf("vec%0d desReg_addr", i), 32'(desReg_addr), 32'(i + 1));
      if (vecs[i].whilo) begin
        chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
        chk($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      end
    end

    run_div("div -7/2", ExeDivOp, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu 100/7", ExeDivuOp, 32'd100, 32'd7, 33, 32'd14, 32'd2);

    // Downstream stall during DONE: result must hold, no new stall request.
    stop = 6'b001000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("hold%0d lo", k), lo, 32'd14);
      chk($sformatf("hold%0d hi", k), hi, 32'd2);
      chk($sformatf("hold%0d whilo", k), 32'(whilo), 32'd1);
      chk($sformatf("hold%0d stopreq_ex", k), 32'(stopreq_ex), 32'd0);
    end
    stop = 6'b0;
    @(posedge clk);
    #1;
    op_ex = ExeNopOp;
    @(negedge clk);
    #1;
    chk("after hold stopreq_ex", 32'(stopreq_ex), 32'd0);
    chk("after hold whilo", 32'(whilo), 32'd0);

    run_div("divu x/0", ExeDivuOp, 32'h00001234, 32'h0, 2, 32'h0, 32'h0);
    run_div("div min/-1", ExeDivOp, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0);

    // Abort a division partway through BUSY.
    @(posedge clk);
    #1;
    op_ex   = ExeDivOp;
    num1_ex = 32'd1000;
    num2_ex = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    chk("busy stopreq_ex", 32'(stopreq_ex), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort stopreq_ex", 32'(stopreq_ex), 32'd0);
    chk("abort whilo", 32'(whilo), 32'd0);
    op_ex = ExeNopOp;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        #1;
        if (whilo || stopreq_ex) seen++;
      end
      chk("post-abort whilo/stopreq pulses", 32'(seen), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
